// File: rtl/fifo_uart_tx32.sv
// Drains 32-bit words from an output FIFO and streams each as four UART 8N1 bytes.
// Byte order is selected by LSB_BYTE_1ST. Bits within a byte always go out LSB first.
module fifo_uart_tx32 #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter bit          LSB_BYTE_1ST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [31:0]      word, word_d;
    logic [7:0]       shreg, shreg_d;
    logic             uart_tx_d, fifo_rd_en_d, busy_d;
    logic [15:0]      words_sent_d;
    logic             bit_end;

    assign bit_end = (cnt == CNT_MAX);

    // Map transmit position (0..3) to the byte lane of the word.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [1:0] lane;
        lane = LSB_BYTE_1ST ? idx : 2'(2'd3 - idx);
        return w[{lane, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            word       <= '0;
            shreg      <= '0;
            uart_tx    <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            byte_idx   <= byte_idx_d;
            word       <= word_d;
            shreg      <= shreg_d;
            uart_tx    <= uart_tx_d;
            fifo_rd_en <= fifo_rd_en_d;
            busy       <= busy_d;
            words_sent <= words_sent_d;
        end
    end

    // Next state plus the next value of every registered output, so each
    // output lines up with the state it belongs to.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        byte_idx_d   = byte_idx;
        word_d       = word;
        shreg_d      = shreg;
        uart_tx_d    = 1'b1;
        fifo_rd_en_d = 1'b0;
        busy_d       = busy;
        words_sent_d = words_sent;

        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d      = S_FETCH;
                    fifo_rd_en_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                word_d     = fifo_rd_data;
                byte_idx_d = '0;
                shreg_d    = pick_byte(fifo_rd_data, 2'd0);
                cnt_d      = '0;
                state_d    = S_START;
                uart_tx_d  = 1'b0;
            end
            S_START: begin
                uart_tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    uart_tx_d = shreg[0];
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                uart_tx_d = shreg[0];
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d   = S_STOP;
                        uart_tx_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shreg_d   = {1'b0, shreg[7:1]};
                        uart_tx_d = shreg[1];
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                uart_tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_idx != 2'd3) begin
                        byte_idx_d = byte_idx + 2'd1;
                        shreg_d    = pick_byte(word, 2'(byte_idx + 2'd1));
                        state_d    = S_START;
                        uart_tx_d  = 1'b0;
                    end else begin
                        words_sent_d = words_sent + 16'd1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
